// File: rtl/lsu_pipe.sv
// lsu_pipe: in-order load/store unit turning RV loads/stores into aligned word requests
// with byte strobes. Define LSU_MISALIGN_TRAP_EN to trap misaligned or illegal accesses.
module lsu_pipe #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_store,
    input  logic [2:0]          op_funct3,
    input  logic [XLEN-1:0]     op_addr,
    input  logic [XLEN-1:0]     op_wdata,
    input  logic [4:0]          op_rd,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [XLEN-1:0]     mem_req_addr,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                trap_valid,
    output logic [XLEN-1:0]     trap_addr,
    output logic                idle
);
    localparam int unsigned BEW  = XLEN / 8;
    localparam int unsigned OFFW = $clog2(BEW);
    localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNTW = PTRW + 1;

    typedef struct packed {
        logic            store;
        logic            uns;
        logic [1:0]      size;
        logic [OFFW-1:0] off;
        logic [4:0]      rd;
    } tag_t;

    logic                ready_en_q;
    logic                req_valid_q, req_we_q;
    logic [XLEN-1:0]     req_addr_q, req_wdata_q;
    logic [BEW-1:0]      req_be_q;
    tag_t                fifo_q [MAX_OUTSTANDING];
    logic [PTRW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]     count_q;
    logic                wb_valid_q, trap_valid_q;
    logic [4:0]          wb_rd_q;
    logic [XLEN-1:0]     wb_data_q, trap_addr_q;

    logic                illegal_c, trap_c, accept_c, push_c, pop_c, msb_c;
    logic [1:0]          size_c;
    logic [OFFW-1:0]     off_c, off_mask_c, off_al_c;
    logic [BEW-1:0]      be_c;
    tag_t                new_tag_c, head_c;
    logic [XLEN-1:0]     shifted_c, fmask_c, ld_c;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // Operation decode: access size, aligned offset, strobes and trap condition
    always_comb begin
        illegal_c  = (op_funct3[1:0] == 2'd3 && (XLEN == 32 || op_funct3[2]))
                   || (op_store && op_funct3[2]);
        size_c     = illegal_c ? 2'd2 : op_funct3[1:0];
        off_c      = op_addr[OFFW-1:0];
        off_mask_c = OFFW'((32'd1 << size_c) - 32'd1);
        off_al_c   = off_c & ~off_mask_c;
        case (size_c)
            2'd0:    be_c = BEW'(4'h1);
            2'd1:    be_c = BEW'(4'h3);
            2'd2:    be_c = BEW'(4'hF);
            default: be_c = '1;
        endcase
        be_c = be_c << off_al_c;
`ifdef LSU_MISALIGN_TRAP_EN
        trap_c = illegal_c || ((off_c & off_mask_c) != '0);
`else
        trap_c = 1'b0;
`endif
        new_tag_c = '{store: op_store, uns: op_funct3[2], size: size_c, off: off_al_c, rd: op_rd};
    end

    assign op_ready = ready_en_q && (!req_valid_q || mem_req_ready)
                    && (count_q < CNTW'(MAX_OUTSTANDING));
    assign accept_c = op_valid && op_ready;
    assign push_c   = accept_c && !trap_c;
    assign pop_c    = mem_rsp_valid && (count_q != '0);
    assign head_c   = fifo_q[rd_ptr_q];

    // Load extraction: shift field down, then sign- or zero-fill above it
    always_comb begin
        shifted_c = mem_rsp_rdata >> {head_c.off, 3'b000};
        case (head_c.size)
            2'd0:    begin fmask_c = XLEN'(8'hFF);         msb_c = shifted_c[7];      end
            2'd1:    begin fmask_c = XLEN'(16'hFFFF);      msb_c = shifted_c[15];     end
            2'd2:    begin fmask_c = XLEN'(32'hFFFF_FFFF); msb_c = shifted_c[31];     end
            default: begin fmask_c = '1;                   msb_c = shifted_c[XLEN-1]; end
        endcase
        ld_c = (shifted_c & fmask_c) | ((!head_c.uns && msb_c) ? ~fmask_c : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_be_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            trap_valid_q <= 1'b0;
            trap_addr_q  <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (push_c) begin
                req_valid_q      <= 1'b1;
                req_we_q         <= op_store;
                req_addr_q       <= {op_addr[XLEN-1:OFFW], OFFW'(0)};
                req_wdata_q      <= op_wdata << {off_al_c, 3'b000};
                req_be_q         <= be_c;
                fifo_q[wr_ptr_q] <= new_tag_c;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end else if (mem_req_ready) begin
                req_valid_q <= 1'b0;
            end
            if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_c && !pop_c)      count_q <= count_q + CNTW'(1);
            else if (!push_c && pop_c) count_q <= count_q - CNTW'(1);
            wb_valid_q <= pop_c && !head_c.store;
            if (pop_c && !head_c.store) begin
                wb_rd_q   <= head_c.rd;
                wb_data_q <= ld_c;
            end
            trap_valid_q <= accept_c && trap_c;
            if (accept_c && trap_c) trap_addr_q <= op_addr;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_be    = req_be_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign trap_valid    = trap_valid_q;
    assign trap_addr     = trap_addr_q;
    assign idle          = !req_valid_q && (count_q == '0);
endmodule

// File: doc/lsu_pipe.md
# lsu_pipe

Parametrised in-order load/store unit that sits between the core's EX/MEM pipeline register and a valid/ready data-memory port. It converts LB/LH/LW/LBU/LHU/SB/SH/SW operations into aligned word requests with byte strobes, so sub-word stores no longer clobber neighbouring bytes. It tracks up to `MAX_OUTSTANDING` in-flight accesses and returns sign- or zero-extended load data to writeback in order.

## Interface
- `XLEN`, 32: data and address width; 32 or 64.
- `MAX_OUTSTANDING`, 4: depth of the in-flight tag FIFO; power of two, at least 1.
- `clk` input 1: single clock, all state on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `op_valid` input 1: operation offered.
- `op_ready` output 1: operation accepted when `op_valid && op_ready`.
- `op_store` input 1: 1 for store, 0 for load.
- `op_funct3` input 3: RV funct3; SD/LD/LWU apply only when `XLEN`=64.
- `op_addr` input XLEN: effective byte address.
- `op_wdata` input XLEN: store data, right-aligned.
- `op_rd` input 5: load destination register.
- `mem_req_valid` output 1, `mem_req_ready` input 1: request handshake.
- `mem_req_we` output 1: write enable.
- `mem_req_addr` output XLEN: address with the low log2(XLEN/8) bits forced to zero.
- `mem_req_wdata` output XLEN: store data shifted into its lanes.
- `mem_req_be` output XLEN/8: byte strobes.
- `mem_rsp_valid` input 1: response, one per request, in order, with no backpressure.
- `mem_rsp_rdata` input XLEN: read word; ignored for stores.
- `wb_valid` output 1: one-cycle pulse when load data is ready.
- `wb_rd` output 5: destination register.
- `wb_data` output XLEN: extended load data.
- `trap_valid` output 1: misaligned-access trap pulse.
- `trap_addr` output XLEN: faulting address.
- `idle` output 1: no request pending and the FIFO is empty.

## Operation
- **Request register.** A one-entry request register holds the pending request. `mem_req_*` outputs come directly from this register. The register is loaded on acceptance and cleared on `mem_req_valid && mem_req_ready`.
- **Acceptance rule.** `op_ready = (!mem_req_valid || mem_req_ready) && (count < MAX_OUTSTANDING)`.
- **Tag FIFO.** On acceptance of a non-trapping op, push {store, funct3, byte offset, rd}. `count` is the number of FIFO entries. An entry stays in the FIFO until its response arrives.
- **Lanes.**
  - Byte access: strobe `1 << off`.
  - Half access: strobe `2'b11 << off`.
  - Word access: strobe `4'hF << off`.
  - Double access (XLEN=64 only): all strobes set.
  - `wdata` is shifted left by `8*off`.
- **Response.** On `mem_rsp_valid`, pop the FIFO head.
  - For a load: extract the field at `8*off` and sign- or zero-extend it per funct3. The next cycle drives `wb_valid`=1 with `wb_rd`/`wb_data`.
  - For a store: no wb pulse.
  - A load to `rd`=0 still pulses `wb_valid`; the regfile discards the write.
- **Count update.**
  - Push and pop in the same cycle: `count` is unchanged; the head pops before the new entry is written.
  - `mem_rsp_valid` while `count`=0 (spurious): ignored, no state change.
- **Illegal funct3** (e.g. 3'b011 when XLEN=32): accepted and treated as a trap when `LSU_MISALIGN_TRAP_EN` is defined. Without the macro it is treated as a word access.
- **Reset** (asynchronous, any time): every output drops to 0, except `idle`=1. `count`, the FIFO pointers and the request register all clear. Responses to pre-reset requests arriving afterwards hit `count`=0 and are ignored.

## Timing
- Accept to `mem_req_valid`: 1 cycle. `mem_req_*` stay stable until taken.
- Back-to-back acceptance: 1 op per cycle while `mem_req_ready`=1 and the FIFO is not full.
- `mem_rsp_valid` to `wb_valid`: 1 cycle, registered.
- Trap: `trap_valid` pulses 1 cycle after acceptance of the faulting op; no request is issued and no FIFO push occurs.
- Full (`count`=MAX_OUTSTANDING): `op_ready`=0. If a response arrives in that cycle, `op_ready` rises the following cycle, never combinationally from `mem_rsp_valid`.
- Pointer wrap: FIFO pointers are log2(MAX_OUTSTANDING) bits and wrap modulo depth. `count` is one bit wider.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned half, word or double access, or an illegal funct3, raises `trap_valid`/`trap_addr`.
  - The op is consumed; no memory side effect.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - The address is aligned down to the access size, which is the low bits of the offset cleared.
  - The access proceeds normally; `trap_valid` is tied to 0.

## Test plan
- **Byte store preserves neighbours.** Memory word at 0x100 = 0xAABBCCDD; SB 0x11 to 0x102 → `be`=4'b0100, `wdata`=0x00110000. A subsequent LW reads 0xAA11CCDD.
- **Sign/zero extension.** Word 0x80F0017F. LB @+0 → 0x0000007F; LB @+3 → 0xFFFFFF80; LHU @+2 → 0x000080F0; LH @+2 → 0xFFFF80F0.
- **Full and back-pressure.** `MAX_OUTSTANDING`=4, responses withheld: 4 loads accepted, the 5th held with `op_ready`=0. Release 1 response → 5th accepted next cycle. The `wb_rd` sequence matches issue order.
- **Misaligned with macro defined.** LW @0x102 → `trap_valid` pulse with `trap_addr`=0x102, no `mem_req_valid`, `count` unchanged. Without the macro: request addr 0x100, `be`=4'hF.
- **Simultaneous push/pop and wrap.** A stream of 20 LW with 1-cycle response latency → `count` stays at 1, pointers wrap ≥4 times, 20 `wb_valid` pulses with correct data.
- **Reset mid-flight.** Assert `rst_n`=0 with 3 outstanding → all outputs 0, `idle`=1. Inject 3 late responses after release → no `wb_valid`.
